// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the serial/parallel shift stages: FSM states and
// bit-order selectors.
package sipo_deserializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam bit MSB_FIRST_ORDER = 1'b1;
    localparam bit LSB_FIRST_ORDER = 1'b0;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input, handshake and status bundle of the SIPO deserializer.
interface sipo_deserializer_if #(
    parameter int WIDTH = 4
) ();

    logic             start;
    logic             serial_in;
    logic             serial_valid;
    logic             data_ready;
    logic             clear_overrun;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             busy;
    logic             overrun;

    modport master (
        output start, serial_in, serial_valid, data_ready, clear_overrun,
        input  data_out, data_valid, busy, overrun
    );

    modport slave (
        input  start, serial_in, serial_valid, data_ready, clear_overrun,
        output data_out, data_valid, busy, overrun
    );

endinterface

// File: rtl/sipo_deserializer_bit_counter.sv
// Counts accepted serial bits of one word; flags the last bit position.
module sipo_deserializer_bit_counter #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign terminal = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out front end: collects WIDTH bits per start pulse and
// holds the word behind a valid/ready handshake, flagging dropped words.
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = MSB_FIRST_ORDER
) (
    input  logic               clock,
    input  logic               reset,
    sipo_deserializer_if.slave bus
);

    state_t           state;
    logic [WIDTH-2:0] shreg;
    logic [WIDTH-1:0] next_word;
    logic [WIDTH-2:0] shift_next;
    logic [WIDTH-1:0] data_out_r;
    logic             data_valid_r;
    logic             busy_r;
    logic             overrun_r;
    logic             accept_bit;
    logic             terminal;
    logic             clear_count;
    logic             slot_free;

    // Only WIDTH-1 bits are stored; the final bit joins the word directly
    // on the completion edge.
    generate
        if (MSB_FIRST) begin : g_msb
            assign next_word  = {shreg, bus.serial_in};
            assign shift_next = next_word[WIDTH-2:0];
        end else begin : g_lsb
            assign next_word  = {bus.serial_in, shreg};
            assign shift_next = next_word[WIDTH-1:1];
        end
    endgenerate

    assign accept_bit  = (state == ST_SHIFT) && bus.serial_valid;
    assign clear_count = ((state == ST_IDLE) && bus.start) || (accept_bit && terminal);
    assign slot_free   = !data_valid_r || bus.data_ready;

    sipo_deserializer_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear_count),
        .enable   (accept_bit),
        .terminal (terminal)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= ST_IDLE;
            shreg        <= '0;
            data_out_r   <= '0;
            data_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            if (bus.clear_overrun) begin
                overrun_r <= 1'b0;
            end
            if (data_valid_r && bus.data_ready) begin
                data_valid_r <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state  <= ST_SHIFT;
                        busy_r <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (bus.serial_valid) begin
                        shreg <= shift_next;
                        if (terminal) begin
                            state  <= ST_IDLE;
                            busy_r <= 1'b0;
                            // A load overrides the transfer's valid drop; a
                            // drop overrides a same-cycle overrun clear.
                            if (slot_free) begin
                                data_out_r   <= next_word;
                                data_valid_r <= 1'b1;
                            end else begin
                                overrun_r <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.data_valid = data_valid_r;
    assign bus.busy       = busy_r;
    assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: MSB-first and LSB-first instances share one
// stimulus stream and are compared against a word-level reference model.
module tb_sipo_deserializer;

    localparam int W = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0, serial_in = 1'b0, serial_valid = 1'b0;
    logic data_ready = 1'b0, clear_overrun = 1'b0;

    always #10 clock = ~clock;

    sipo_deserializer_if #(.WIDTH(W)) bus_m ();
    sipo_deserializer_if #(.WIDTH(W)) bus_l ();

    assign bus_m.start         = start;
    assign bus_m.serial_in     = serial_in;
    assign bus_m.serial_valid  = serial_valid;
    assign bus_m.data_ready    = data_ready;
    assign bus_m.clear_overrun = clear_overrun;
    assign bus_l.start         = start;
    assign bus_l.serial_in     = serial_in;
    assign bus_l.serial_valid  = serial_valid;
    assign bus_l.data_ready    = data_ready;
    assign bus_l.clear_overrun = clear_overrun;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clock (clock),
        .reset (reset),
        .bus   (bus_m.slave)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clock (clock),
        .reset (reset),
        .bus   (bus_l.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: a word is the list of bits received since start;
    // bit order only matters when the list is turned into a number.
    bit         m_collect = 1'b0;
    bit         m_bits[$];
    logic [W-1:0] m_out_m = '0, m_out_l = '0;
    bit         m_valid = 1'b0, m_ovr = 1'b0;

    task automatic model_step();
        bit done = 1'b0;
        bit nv, novr;
        logic [W-1:0] wm, wl;
        if (!reset) begin
            m_collect = 1'b0; m_bits.delete();
            m_out_m = '0; m_out_l = '0; m_valid = 1'b0; m_ovr = 1'b0;
            return;
        end
        if (!m_collect) begin
            if (start) begin
                m_collect = 1'b1;
                m_bits.delete();
            end
        end else if (serial_valid) begin
            m_bits.push_back(serial_in);
            if (m_bits.size() == W) begin
                done = 1'b1;
                m_collect = 1'b0;
            end
        end
        nv   = m_valid && !data_ready;
        novr = m_ovr && !clear_overrun;
        if (done) begin
            if (!m_valid || data_ready) begin
                wm = '0; wl = '0;
                for (int i = 0; i < W; i++) begin
                    wm = wm + (W'(m_bits[i]) << (W - 1 - i));
                    wl = wl + (W'(m_bits[i]) << i);
                end
                m_out_m = wm; m_out_l = wl; nv = 1'b1;
            end else begin
                novr = 1'b1;
            end
        end
        m_valid = nv;
        m_ovr   = novr;
    endtask

    task automatic tick(input bit st, input bit sin, input bit sv, input bit rdy,
                        input bit clr, input bit rst_n);
        start = st; serial_in = sin; serial_valid = sv;
        data_ready = rdy; clear_overrun = clr; reset = rst_n;
        @(posedge clock);
        model_step();
        #1;
        check("busy_m",  32'(bus_m.busy),       32'(m_collect));
        check("busy_l",  32'(bus_l.busy),       32'(m_collect));
        check("valid_m", 32'(bus_m.data_valid), 32'(m_valid));
        check("valid_l", 32'(bus_l.data_valid), 32'(m_valid));
        check("data_m",  32'(bus_m.data_out),   32'(m_out_m));
        check("data_l",  32'(bus_l.data_out),   32'(m_out_l));
        check("ovr_m",   32'(bus_m.overrun),    32'(m_ovr));
        check("ovr_l",   32'(bus_l.overrun),    32'(m_ovr));
    endtask

    // Serial order is w[W-1] first.
    task automatic send_word(input logic [W-1:0] w, input bit rdy_last);
        tick(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < W; i++)
            tick(0, w[W-1-i], 1, (i == W-1) ? rdy_last : 1'b0, 0, 1);
    endtask

    initial begin
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        check("rst_valid", 32'(bus_m.data_valid), 32'd0);
        check("rst_busy",  32'(bus_m.busy),       32'd0);
        check("rst_data",  32'(bus_m.data_out),   32'd0);

        // Start cycle carries a valid bit that must not be captured.
        tick(1, 1, 1, 0, 0, 1);
        tick(0, 1, 1, 0, 0, 1);
        tick(1, 0, 1, 0, 0, 1);
        tick(0, 1, 1, 0, 0, 1);
        check("t1_early_valid", 32'(bus_m.data_valid), 32'd0);
        check("t1_busy_mid",    32'(bus_m.busy),       32'd1);
        tick(0, 1, 1, 0, 0, 1);
        check("t1_data_msb", 32'(bus_m.data_out),   32'h b);
        check("t2_data_lsb", 32'(bus_l.data_out),   32'h d);
        check("t1_valid",    32'(bus_m.data_valid), 32'd1);
        check("t1_busy",     32'(bus_m.busy),       32'd0);
        tick(0, 0, 0, 1, 0, 1);
        check("t1_accepted", 32'(bus_m.data_valid), 32'd0);

        // Gapped bits 0,1,1,0.
        tick(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < W; i++) begin
            logic [W-1:0] pat;
            pat = 4'b0110;
            tick(0, pat[W-1-i], 1, 0, 0, 1);
            if (i != W-1) begin
                for (int g = 0; g < 3; g++) tick(0, 1, 0, 0, 0, 1);
                check("t3_no_early", 32'(bus_m.data_valid), 32'd0);
            end
        end
        check("t3_data",  32'(bus_m.data_out),   32'h6);
        check("t3_valid", 32'(bus_m.data_valid), 32'd1);
        tick(0, 0, 0, 1, 0, 1);

        // Overrun while downstream stalls.
        send_word(4'b0011, 1'b0);
        check("t4_first", 32'(bus_m.data_out), 32'h3);
        send_word(4'b1100, 1'b0);
        check("t4_kept", 32'(bus_m.data_out), 32'h3);
        check("t4_ovr",  32'(bus_m.overrun),  32'd1);
        tick(0, 0, 0, 0, 1, 1);
        check("t4_ovr_clr", 32'(bus_m.overrun), 32'd0);
        tick(0, 0, 0, 1, 0, 1);

        // Reset mid-word.
        tick(1, 0, 0, 0, 0, 1);
        tick(0, 1, 1, 0, 0, 1);
        tick(0, 0, 1, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 0);
        check("t5_busy",  32'(bus_m.busy),       32'd0);
        check("t5_valid", 32'(bus_m.data_valid), 32'd0);
        send_word(4'b1001, 1'b0);
        check("t5_data", 32'(bus_m.data_out), 32'h9);
        tick(0, 0, 0, 1, 0, 1);

        // Same-edge transfer and reload.
        send_word(4'b0101, 1'b0);
        check("t6_pending", 32'(bus_m.data_out), 32'h5);
        send_word(4'b1010, 1'b1);
        check("t6_valid", 32'(bus_m.data_valid), 32'd1);
        check("t6_data",  32'(bus_m.data_out),   32'ha);
        check("t6_ovr",   32'(bus_m.overrun),    32'd0);

        for (int n = 0; n < 600; n++)
            tick($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 59) != 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
